// File: rtl/adc_avg_scale.sv
// Averages 2^LOG2_SAMPS channel-tagged ADC samples per channel, scales each average by a
// fixed-point gain and writes one result per channel, then pulses DONE. Optional macro: ADC_AVG_OFFSET_EN.
module adc_avg_scale #(
    parameter int FP_WIDTH    = 64,
    parameter int INT_WIDTH   = 16,
    parameter int ADC_WIDTH   = 12,
    parameter int NUM_CH      = 4,
    parameter int LOG2_SAMPS  = 10,
    parameter int SCALE_SHIFT = 11,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 ADC_CLK,
    input  logic                 ADC_RST_N,
    input  logic [ADC_WIDTH-1:0] ADC_DATA_IN,
    input  logic [CH_W-1:0]      ADC_CH_IN,
    input  logic                 ADC_VALID_IN,
    input  logic                 START,
    input  logic [FP_WIDTH-1:0]  GAIN_IN,
    input  logic [ADC_WIDTH-1:0] OFFSET_IN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [FP_WIDTH-1:0]  OUT_DATA,
    output logic [CH_W-1:0]      OUT_CH,
    output logic                 REG_WRITE
);
    localparam int ACC_W  = ADC_WIDTH + LOG2_SAMPS;
    localparam int CNT_W  = LOG2_SAMPS + 1;
    localparam int PROD_W = ADC_WIDTH + FP_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_SCALE, S_WRITE, S_FIN} state_t;

    state_t              state, state_nxt;
    logic [ACC_W-1:0]    acc [NUM_CH];
    logic [CNT_W-1:0]    cnt [NUM_CH];
    logic [CH_W-1:0]     idx;
    logic [FP_WIDTH-1:0] gain_q;
    logic [NUM_CH-1:0]   hit, full, last, full_nxt;
    logic                take;
    logic [ADC_WIDTH-1:0] sample;
    logic [ADC_WIDTH-1:0] avg;
    logic [PROD_W-1:0]   prod, prod_sh;
    logic [FP_WIDTH-1:0] result;

`ifdef ADC_AVG_OFFSET_EN
    logic [ADC_WIDTH-1:0] offset_q;

    always_ff @(posedge ADC_CLK or negedge ADC_RST_N) begin
        if (!ADC_RST_N) begin
            offset_q <= '0;
        end else if (state == S_IDLE && START) begin
            offset_q <= OFFSET_IN;
        end
    end

    // Clamp at zero rather than wrap when the sample sits below the offset.
    assign sample = (ADC_DATA_IN > offset_q) ? (ADC_DATA_IN - offset_q) : '0;
`else
    logic unused_offset;
    assign unused_offset = ^OFFSET_IN;
    assign sample        = ADC_DATA_IN;
`endif

    always_comb begin
        hit      = '0;
        full     = '0;
        last     = '0;
        full_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit[c]  = (ADC_CH_IN == CH_W'(c));
            full[c] = cnt[c][LOG2_SAMPS];
            last[c] = (cnt[c] == CNT_W'((1 << LOG2_SAMPS) - 1));
        end
        // Out-of-range tags match no channel, so they fall out here with full-channel samples.
        take = (state == S_ACCUM) && ADC_VALID_IN && (|(hit & ~full));
        for (int c = 0; c < NUM_CH; c++) begin
            full_nxt[c] = full[c] | (take & hit[c] & last[c]);
        end
    end

    always_comb begin
        avg     = acc[idx][ACC_W-1:LOG2_SAMPS];
        prod    = PROD_W'(avg) * PROD_W'(gain_q);
        prod_sh = prod >> SCALE_SHIFT;
        result  = (|prod_sh[PROD_W-1:FP_WIDTH]) ? '1 : prod_sh[FP_WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_ACCUM;
            S_ACCUM: if (&full_nxt) state_nxt = S_SCALE;
            S_SCALE: state_nxt = S_WRITE;
            S_WRITE: state_nxt = (idx == CH_W'(NUM_CH - 1)) ? S_FIN : S_SCALE;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ADC_CLK or negedge ADC_RST_N) begin
        if (!ADC_RST_N) begin
            state    <= S_IDLE;
            idx      <= '0;
            gain_q   <= '0;
            OUT_DATA <= '0;
            OUT_CH   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (START) gain_q <= GAIN_IN;
                S_CLEAR: begin
                    idx <= '0;
                    for (int c = 0; c < NUM_CH; c++) begin
                        acc[c] <= '0;
                        cnt[c] <= '0;
                    end
                end
                S_ACCUM: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (take && hit[c]) begin
                            acc[c] <= acc[c] + ACC_W'(sample);
                            cnt[c] <= cnt[c] + 1'b1;
                        end
                    end
                end
                S_SCALE: begin
                    OUT_DATA <= result;
                    OUT_CH   <= idx;
                end
                S_WRITE: if (idx != CH_W'(NUM_CH - 1)) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign BUSY      = (state != S_IDLE);
    assign REG_WRITE = (state == S_WRITE);
    assign DONE      = (state == S_FIN);

endmodule

// File: tb/tb_adc_avg_scale.sv
// Directed bench for adc_avg_scale: two-channel vector table plus hand-written
// sequences for discards, continuous mode, mid-run reset and a three-channel build.
module tb_adc_avg_scale;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] dat;
    logic        ch;
    logic        vld;
    logic        start;
    logic [63:0] gain;
    logic [11:0] offset;
    logic        busy, done, reg_write;
    logic [63:0] out_data;
    logic        out_ch;

    logic [11:0] dat3;
    logic [1:0]  ch3;
    logic        vld3, start3;
    logic        busy3, done3, rw3;
    logic [63:0] od3;
    logic [1:0]  oc3;

    always #5 clk = ~clk;

    adc_avg_scale #(.FP_WIDTH(64), .INT_WIDTH(16), .ADC_WIDTH(12), .NUM_CH(2),
                    .LOG2_SAMPS(2), .SCALE_SHIFT(11)) u_dut (
        .ADC_CLK(clk), .ADC_RST_N(rst_n), .ADC_DATA_IN(dat), .ADC_CH_IN(ch),
        .ADC_VALID_IN(vld), .START(start), .GAIN_IN(gain), .OFFSET_IN(offset),
        .BUSY(busy), .DONE(done), .OUT_DATA(out_data), .OUT_CH(out_ch),
        .REG_WRITE(reg_write));

    adc_avg_scale #(.FP_WIDTH(64), .INT_WIDTH(16), .ADC_WIDTH(12), .NUM_CH(3),
                    .LOG2_SAMPS(2), .SCALE_SHIFT(11)) u_dut3 (
        .ADC_CLK(clk), .ADC_RST_N(rst_n), .ADC_DATA_IN(dat3), .ADC_CH_IN(ch3),
        .ADC_VALID_IN(vld3), .START(start3), .GAIN_IN(gain), .OFFSET_IN(offset),
        .BUSY(busy3), .DONE(done3), .OUT_DATA(od3), .OUT_CH(oc3),
        .REG_WRITE(rw3));

    typedef struct {
        logic [63:0]      g;
        logic [3:0][11:0] s0;
        logic [3:0][11:0] s1;
        logic [63:0]      e0;
        logic [63:0]      e1;
    } vec_t;

    vec_t vecs[5];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int nw, done_n, done_cyc, overlap, n3, done3_n;
    logic [63:0] wr_dat[8];
    logic        wr_ch[8];
    int          wr_cyc[8];
    logic [63:0] w3_dat[8];
    logic [1:0]  w3_ch[8];

    logic        sv_a[32];
    logic        sc_a[32];
    logic [11:0] sd_a[32];
    int          slen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (reg_write && nw < 8) begin
            wr_dat[nw] = out_data;
            wr_ch[nw]  = out_ch;
            wr_cyc[nw] = cyc;
            nw++;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (reg_write && done) overlap++;
        if (rw3 && n3 < 8) begin
            w3_dat[n3] = od3;
            w3_ch[n3]  = oc3;
            n3++;
        end
        if (done3) done3_n++;
    endtask

    task automatic push(input logic v, input logic c, input logic [11:0] d);
        sv_a[slen] = v;
        sc_a[slen] = c;
        sd_a[slen] = d;
        slen++;
    endtask

    // A junk sample is presented during CLEAR; it must not be accumulated.
    task automatic run(input string nm, input logic [63:0] g, input logic [63:0] e0,
                       input logic [63:0] e1, input logic keep);
        int s;
        int budget;
        nw = 0; done_n = 0; overlap = 0; done_cyc = 0;
        gain = g; start = 1'b1; vld = 1'b1; ch = 1'b0; dat = 12'd4095;
        tick();
        chk({nm, " busy_at_start"}, 64'(busy), 64'd1);
        start = keep;
        tick();
        for (int i = 0; i < slen; i++) begin
            vld = sv_a[i]; ch = sc_a[i]; dat = sd_a[i];
            tick();
        end
        s = cyc;
        vld = 1'b0;
        budget = 0;
        while (done_n == 0 && budget < 40) begin
            tick();
            budget++;
        end
        chk({nm, " done_count"}, 64'(done_n), 64'd1);
        chk({nm, " write_count"}, 64'(nw), 64'd2);
        chk({nm, " ch0_tag"}, 64'(wr_ch[0]), 64'd0);
        chk({nm, " ch1_tag"}, 64'(wr_ch[1]), 64'd1);
        chk({nm, " ch0_data"}, wr_dat[0], e0);
        chk({nm, " ch1_data"}, wr_dat[1], e1);
        chk({nm, " ch0_write_cycle"}, 64'(wr_cyc[0]), 64'(s + 1));
        chk({nm, " ch1_write_cycle"}, 64'(wr_cyc[1]), 64'(s + 3));
        chk({nm, " done_cycle"}, 64'(done_cyc), 64'(s + 4));
        chk({nm, " write_done_overlap"}, 64'(overlap), 64'd0);
        tick();
        chk({nm, " busy_after_fin"}, 64'(busy), 64'd0);
        chk({nm, " hold_data"}, out_data, e1);
    endtask

    task automatic load_vec(input int k);
        slen = 0;
        for (int j = 0; j < 4; j++) begin
            push(1'b1, 1'b0, vecs[k].s0[j]);
            push(1'b1, 1'b1, vecs[k].s1[j]);
        end
    endtask

    initial begin
        int budget;
        vecs[0] = '{64'h0014_0000_0000_0000, {4{12'd2048}}, {4{12'd1024}},
                    64'h0014_0000_0000_0000, 64'h000A_0000_0000_0000};
        vecs[1] = '{64'h0800_0000_0000_0000, {12'd5, 12'd3, 12'd2, 12'd1}, {4{12'd4095}},
                    64'h0002_0000_0000_0000, 64'h0FFF_0000_0000_0000};
        vecs[2] = '{64'hFFFF_0000_0000_0000, {4{12'd4095}}, {12'd3, 12'd0, 12'd0, 12'd0},
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[3] = '{64'h0001_0000_0000_0000, {12'd40, 12'd30, 12'd20, 12'd10}, {4{12'd7}},
                    64'd25 << 37, 64'd7 << 37};
        vecs[4] = '{64'hFFFF_0000_0000_0000, {4{12'd2048}}, {4{12'd2049}},
                    64'hFFFF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};

        rst_n = 1'b0; dat = '0; ch = 1'b0; vld = 1'b0; start = 1'b0;
        gain = '0; offset = '0; dat3 = '0; ch3 = '0; vld3 = 1'b0; start3 = 1'b0;
        n3 = 0; done3_n = 0;
        #12;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset reg_write", 64'(reg_write), 64'd0);
        chk("reset out_data", out_data, 64'd0);
        chk("reset out_ch", 64'(out_ch), 64'd0);
        #3 rst_n = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) begin
            load_vec(k);
            run($sformatf("vec%0d", k), vecs[k].g, vecs[k].e0, vecs[k].e1, 1'b0);
        end

        // Full-channel extras and an invalid beat must leave vec0 results unchanged.
        slen = 0;
        for (int j = 0; j < 4; j++) push(1'b1, 1'b0, 12'd2048);
        push(1'b0, 1'b0, 12'd4095);
        push(1'b1, 1'b0, 12'd4095);
        push(1'b1, 1'b0, 12'd4095);
        for (int j = 0; j < 4; j++) push(1'b1, 1'b1, 12'd1024);
        run("extras", vecs[0].g, vecs[0].e0, vecs[0].e1, 1'b0);

        // Continuous mode: the second run's busy_at_start check proves a single IDLE cycle.
        load_vec(0);
        run("cont_a", vecs[0].g, vecs[0].e0, vecs[0].e1, 1'b1);
        load_vec(1);
        run("cont_b", vecs[1].g, vecs[1].e0, vecs[1].e1, 1'b0);

        // Reset during ACCUM.
        gain = vecs[0].g; start = 1'b1; vld = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            vld = 1'b1; ch = j[0]; dat = 12'd2048;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset out_data", out_data, 64'd0);
        chk("midreset out_ch", 64'(out_ch), 64'd0);
        chk("midreset reg_write", 64'(reg_write), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        nw = 0; done_n = 0;
        tick();
        tick();
        #3 rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            vld = 1'b1; ch = j[0]; dat = 12'd100;
            tick();
        end
        vld = 1'b0;
        chk("postreset writes", 64'(nw), 64'd0);
        chk("postreset dones", 64'(done_n), 64'd0);
        chk("postreset busy", 64'(busy), 64'd0);
        load_vec(2);
        run("after_reset", vecs[2].g, vecs[2].e0, vecs[2].e1, 1'b0);

        // Offset handling: subtracted and clamped only when the feature is built.
        offset = 12'd100;
        slen = 0;
        push(1'b1, 1'b0, 12'd50);  push(1'b1, 1'b1, 12'd100);
        push(1'b1, 1'b0, 12'd300); push(1'b1, 1'b1, 12'd101);
        push(1'b1, 1'b0, 12'd300); push(1'b1, 1'b1, 12'd4095);
        push(1'b1, 1'b0, 12'd300); push(1'b1, 1'b1, 12'd0);
`ifdef ADC_AVG_OFFSET_EN
        run("offset", 64'h0800_0000_0000_0000, 64'd150 << 48, 64'd999 << 48, 1'b0);
`else
        run("offset", 64'h0800_0000_0000_0000, 64'd237 << 48, 64'd1074 << 48, 1'b0);
`endif
        offset = '0;

        // Three-channel build: tag 3 is out of range and must be discarded.
        gain = 64'h0800_0000_0000_0000; n3 = 0; done3_n = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick();
        for (int j = 0; j < 4; j++) begin
            vld3 = 1'b1; ch3 = 2'd0; dat3 = 12'd100;  tick();
            vld3 = 1'b1; ch3 = 2'd3; dat3 = 12'd4095; tick();
            vld3 = 1'b1; ch3 = 2'd1; dat3 = 12'd200;  tick();
            vld3 = 1'b1; ch3 = 2'd2; dat3 = 12'd300;  tick();
        end
        vld3 = 1'b0;
        budget = 0;
        while (done3_n == 0 && budget < 40) begin
            tick();
            budget++;
        end
        chk("ch3 done_count", 64'(done3_n), 64'd1);
        chk("ch3 write_count", 64'(n3), 64'd3);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("ch3 tag%0d", c), 64'(w3_ch[c]), 64'(c));
            chk($sformatf("ch3 data%0d", c), w3_dat[c], 64'(c + 1) * (64'd100 << 48));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
